// File: rtl/unit_output_sync_pkg.sv
// Shared constants and types for the unit output path: bus width, header field
// layout, packet type codes, thread-state encoding and the transmit FSM states.
package unit_output_sync_pkg;

    localparam int UNIT_OUTPUT_WIDTH = 8;
    localparam int WORD_WIDTH        = 32;
    localparam int MAX_WORDS_MSB     = 4;

    // Header chunk layout: type in the low bits, thread number directly above.
    localparam int HDR_TYPE_LSB   = 0;
    localparam int HDR_TYPE_W     = 3;
    localparam int HDR_THREAD_LSB = 3;

    localparam logic [2:0] OUTPUT_PKT_TYPE_RESULT = 3'd0;
    localparam logic [2:0] OUTPUT_PKT_TYPE_STATUS = 3'd1;
    localparam logic [2:0] OUTPUT_PKT_TYPE_DATA   = 3'd2;
    localparam logic [2:0] OUTPUT_PKT_TYPE_DEBUG  = 3'd3;

    localparam int         THREAD_STATE_MSB  = 1;
    localparam logic [1:0] THREAD_STATE_NONE = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_READ,
        ST_WAIT_MEM,
        ST_SEND,
        ST_TS_WR
    } state_t;

endpackage

// File: rtl/unit_output_sync_serializer.sv
// Holds one 32-bit memory word and presents it low chunk first, one
// OUTPUT_WIDTH-bit chunk per advance.
module unit_output_sync_serializer
    import unit_output_sync_pkg::*;
#(
    parameter int OUTPUT_WIDTH = UNIT_OUTPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [WORD_WIDTH-1:0]   load_data,
    input  logic                    advance,
    output logic [OUTPUT_WIDTH-1:0] dout,
    output logic                    last_chunk
);

    localparam int RATIO = WORD_WIDTH / OUTPUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [WORD_WIDTH-1:0] word_reg;
    logic [WORD_WIDTH-1:0] shifted;
    logic [CNT_W-1:0]      chunk_cnt_reg;

    // Right shift by one chunk, built slot by slot; the top slot fills with zeros.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_shift
            if (gi == RATIO - 1) begin : g_top
                assign shifted[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH] = '0;
            end else begin : g_mid
                assign shifted[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH] =
                    word_reg[(gi+1)*OUTPUT_WIDTH +: OUTPUT_WIDTH];
            end
        end
    endgenerate

    assign dout       = word_reg[OUTPUT_WIDTH-1:0];
    assign last_chunk = (chunk_cnt_reg == CNT_W'(RATIO - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            word_reg      <= '0;
            chunk_cnt_reg <= '0;
        end else if (load) begin
            word_reg      <= load_data;
            chunk_cnt_reg <= '0;
        end else if (advance) begin
            word_reg      <= shifted;
            chunk_cnt_reg <= last_chunk ? '0 : chunk_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/unit_output_sync.sv
// Transmit side of the unit packet bus: reads a thread's result words from
// main memory, emits header + data chunks, then marks the thread state NONE.
module unit_output_sync
    import unit_output_sync_pkg::*;
#(
    parameter int N_CORES       = 4,
    parameter int N_THREADS     = 4 * N_CORES,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
    parameter int OUTPUT_WIDTH  = UNIT_OUTPUT_WIDTH,
    parameter int MEM_TOTAL_MSB = N_THREADS_MSB + MAX_WORDS_MSB + 1
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [N_THREADS_MSB:0]      req_thread,
    input  logic [2:0]                  req_type,
    input  logic [MAX_WORDS_MSB:0]      req_n_words,
    output logic                        mem_rd_en,
    output logic [MEM_TOTAL_MSB:0]      mem_addr,
    input  logic [WORD_WIDTH-1:0]       mem_dout,
    output logic [OUTPUT_WIDTH-1:0]     dout,
    output logic                        ctrl,
    output logic                        valid,
    input  logic                        rd_en,
    output logic [N_THREADS_MSB:0]      ts_num,
    output logic                        ts_wr_en,
    output logic [THREAD_STATE_MSB:0]   ts_wr
);

    state_t                   state_reg, state_next;
    logic [N_THREADS_MSB:0]   thread_reg;
    logic [2:0]               type_reg;
    logic [MAX_WORDS_MSB:0]   n_words_reg;
    logic [MAX_WORDS_MSB:0]   word_cnt_reg, word_cnt_next;
    logic                     latch;
    logic                     ser_load, ser_advance, ser_last;
    logic [OUTPUT_WIDTH-1:0]  ser_dout, header;
    logic                     last_word;

    unit_output_sync_serializer #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_serializer (
        .clk        (CLK),
        .reset      (reset),
        .load       (ser_load),
        .load_data  (mem_dout),
        .advance    (ser_advance),
        .dout       (ser_dout),
        .last_chunk (ser_last)
    );

    always_comb begin
        header = '0;
        header[HDR_TYPE_LSB +: HDR_TYPE_W]        = type_reg;
        header[HDR_THREAD_LSB +: N_THREADS_MSB+1] = thread_reg;
    end

    // Only meaningful in SEND, where n_words is known to be nonzero.
    assign last_word = (word_cnt_reg == n_words_reg - (MAX_WORDS_MSB+1)'(1));
    assign mem_addr  = {thread_reg, word_cnt_reg};
    assign ts_num    = thread_reg;
    assign ts_wr     = THREAD_STATE_NONE;

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        req_ready     = 1'b0;
        valid         = 1'b0;
        ctrl          = 1'b0;
        dout          = '0;
        mem_rd_en     = 1'b0;
        ts_wr_en      = 1'b0;
        ser_load      = 1'b0;
        ser_advance   = 1'b0;
        latch         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    latch      = 1'b1;
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                valid = 1'b1;
                ctrl  = 1'b1;
                dout  = header;
                if (rd_en)
                    state_next = (n_words_reg == '0) ? ST_TS_WR : ST_READ;
            end
            ST_READ: begin
                mem_rd_en  = 1'b1;
                state_next = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                ser_load   = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                valid = 1'b1;
                dout  = ser_dout;
                ctrl  = ser_last & last_word;
                if (rd_en) begin
                    ser_advance = 1'b1;
                    if (ser_last) begin
                        if (last_word) begin
                            state_next = ST_TS_WR;
                        end else begin
                            word_cnt_next = word_cnt_reg + (MAX_WORDS_MSB+1)'(1);
                            state_next    = ST_READ;
                        end
                    end
                end
            end
            ST_TS_WR: begin
                ts_wr_en      = 1'b1;
                word_cnt_next = '0;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            word_cnt_reg <= '0;
            thread_reg   <= '0;
            type_reg     <= '0;
            n_words_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            if (latch) begin
                thread_reg  <= req_thread;
                type_reg    <= req_type;
                n_words_reg <= req_n_words;
            end
        end
    end

endmodule

// File: tb/tb_unit_output_sync.sv
// Directed bench for unit_output_sync: table of packets plus hand-written
// sequences for request-while-busy and reset mid-packet.
module tb_unit_output_sync;

    logic        CLK = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_thread;
    logic [2:0]  req_type;
    logic [4:0]  req_n_words;
    logic        mem_rd_en;
    logic [8:0]  mem_addr;
    logic [31:0] mem_dout;
    logic [7:0]  dout;
    logic        ctrl;
    logic        valid;
    logic        rd_en;
    logic [3:0]  ts_num;
    logic        ts_wr_en;
    logic [1:0]  ts_wr;

    unit_output_sync dut (
        .CLK         (CLK),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_thread  (req_thread),
        .req_type    (req_type),
        .req_n_words (req_n_words),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .dout        (dout),
        .ctrl        (ctrl),
        .valid       (valid),
        .rd_en       (rd_en),
        .ts_num      (ts_num),
        .ts_wr_en    (ts_wr_en),
        .ts_wr       (ts_wr)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic stall_mode = 1'b0;

    logic [31:0] mem [0:511];
    logic [8:0]  chunk_q[$];
    int          stamp_q[$];
    logic [8:0]  addr_q[$];
    logic [3:0]  ts_num_q[$];
    logic [3:0]  ts_log[$];
    int          ts_cnt = 0;
    int          rd_cnt = 0;
    bit          hold_pending = 0;
    logic [8:0]  hold_val;
    int          acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) if (mem_rd_en) mem_dout <= mem[mem_addr];

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            rd_en = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Bus monitor: collects transfers, checks the hold rule, logs ts/mem activity.
    always @(negedge CLK) begin
        if (reset) begin
            hold_pending = 0;
        end else begin
            if (hold_pending)
                check("hold", {23'd0, valid, ctrl, dout}, {23'd0, 1'b1, hold_val});
            if (valid && rd_en) begin
                chunk_q.push_back({ctrl, dout});
                stamp_q.push_back(cyc);
            end
            hold_pending = valid && !rd_en;
            hold_val     = {ctrl, dout};
        end
        if (ts_wr_en) begin
            ts_cnt++;
            ts_num_q.push_back(ts_num);
            ts_log.push_back(ts_num);
        end
        if (mem_rd_en) begin
            rd_cnt++;
            addr_q.push_back(mem_addr);
        end
    end

    task automatic clear_mon();
        chunk_q.delete();
        stamp_q.delete();
        addr_q.delete();
        ts_num_q.delete();
        ts_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic issue_req(input logic [3:0] t, input logic [2:0] ty, input logic [4:0] n);
        int k;
        for (k = 0; k < 200; k++) begin
            if (req_ready) break;
            @(posedge CLK);
            #1;
        end
        if (k == 200) check("req_ready_timeout", 0, 1);
        clear_mon();
        req_valid   = 1'b1;
        req_thread  = t;
        req_type    = ty;
        req_n_words = n;
        @(posedge CLK);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic finish_packet(input logic [3:0] t, input logic [4:0] n, input logic [7:0] exp_hdr,
                                 input bit has_last, input logic [7:0] exp_last, input bit lat_chk);
        int k;
        int exp_len;
        int w;
        int c;
        logic [8:0] expv;
        for (k = 0; k < 2000; k++) begin
            if (ts_cnt > 0) break;
            @(posedge CLK);
            #1;
        end
        if (k == 2000) check("done_timeout", 0, 1);
        repeat (2) @(posedge CLK);
        #1;
        check("req_ready_after", {31'd0, req_ready}, 1);
        check("ts_count", ts_cnt, 1);
        if (ts_num_q.size() > 0) check("ts_num", {28'd0, ts_num_q[0]}, {28'd0, t});
        check("mem_rd_count", rd_cnt, {27'd0, n});
        for (int i = 0; i < addr_q.size(); i++)
            check("mem_addr", {23'd0, addr_q[i]}, {23'd0, t, 5'(i)});
        exp_len = 1 + 4 * n;
        check("chunk_count", chunk_q.size(), exp_len);
        for (int i = 0; i < chunk_q.size() && i < exp_len; i++) begin
            if (i == 0) begin
                expv = {1'b1, exp_hdr};
            end else begin
                w = (i - 1) / 4;
                c = (i - 1) % 4;
                expv = {(w == n - 1) && (c == 3), mem[{t, 5'(w)}][c*8 +: 8]};
            end
            check($sformatf("chunk%0d", i), {23'd0, chunk_q[i]}, {23'd0, expv});
        end
        if (has_last && chunk_q.size() > 0)
            check("last_chunk", {24'd0, chunk_q[chunk_q.size()-1][7:0]}, {24'd0, exp_last});
        if (lat_chk && stamp_q.size() > 1) begin
            check("hdr_latency", stamp_q[0] - acc_cyc, 0);
            if (n > 0) check("data_latency", stamp_q[1] - acc_cyc, 3);
        end
        $display("packet thread=%0d n_words=%0d chunks=%0d ts_writes=%0d", t, n, chunk_q.size(), ts_cnt);
    endtask

    typedef struct {
        logic [3:0] thread;
        logic [2:0] ptype;
        logic [4:0] n_words;
        bit         stall;
        logic [7:0] exp_hdr;
        bit         has_last;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k;
        for (int a = 0; a < 512; a++)
            mem[a] = (32'(a) + 32'd1) * 32'h01030507 ^ 32'hC3A50F00;
        mem[{4'd5, 5'd0}] = 32'h44332211;
        mem[{4'd5, 5'd1}] = 32'h88776655;

        vecs[0] = '{4'd5,  3'd2, 5'd2,  1'b0, 8'h2A, 1'b1, 8'h88};
        vecs[1] = '{4'd3,  3'd1, 5'd0,  1'b0, 8'h19, 1'b1, 8'h19};
        vecs[2] = '{4'd10, 3'd4, 5'd4,  1'b1, 8'h54, 1'b0, 8'h00};
        vecs[3] = '{4'd10, 3'd4, 5'd4,  1'b0, 8'h54, 1'b0, 8'h00};
        vecs[4] = '{4'd0,  3'd7, 5'd1,  1'b0, 8'h07, 1'b0, 8'h00};
        vecs[5] = '{4'd15, 3'd3, 5'd1,  1'b0, 8'h7B, 1'b0, 8'h00};
        vecs[6] = '{4'd1,  3'd0, 5'd31, 1'b1, 8'h08, 1'b0, 8'h00};

        reset = 1'b1; req_valid = 1'b0; req_thread = '0; req_type = '0; req_n_words = '0;
        rd_en = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready", {31'd0, req_ready}, 1);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_ctrl_dout", {23'd0, ctrl, dout}, 0);
        check("rst_rd_ts", {30'd0, mem_rd_en, ts_wr_en}, 0);
        check("ts_wr_const", {30'd0, ts_wr}, 0);
        @(posedge CLK);
        #1;
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            stall_mode = vecs[v].stall;
            issue_req(vecs[v].thread, vecs[v].ptype, vecs[v].n_words);
            finish_packet(vecs[v].thread, vecs[v].n_words, vecs[v].exp_hdr,
                          vecs[v].has_last, vecs[v].exp_last, !vecs[v].stall);
        end
        stall_mode = 1'b0;
        check("ts_log_len", ts_log.size(), 7);
        if (ts_log.size() == 7) begin
            check("ts_order_a", {28'd0, ts_log[4]}, 0);
            check("ts_order_b", {28'd0, ts_log[5]}, 15);
        end

        // Request for another thread while a packet is in flight must be ignored.
        issue_req(4'd2, 3'd5, 5'd3);
        for (k = 0; k < 200 && chunk_q.size() < 3; k++) begin
            @(posedge CLK);
            #1;
        end
        repeat (4) begin
            check("busy_req_ready", {31'd0, req_ready}, 0);
            req_valid = 1'b1; req_thread = 4'd9; req_type = 3'd1; req_n_words = 5'd1;
            @(posedge CLK);
            #1;
        end
        req_valid = 1'b0;
        finish_packet(4'd2, 5'd3, 8'h15, 1'b0, 8'h00, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        check("no_stray_packet", chunk_q.size(), 13);

        // Reset during the second data word aborts the packet without a ts write.
        issue_req(4'd6, 3'd1, 5'd2);
        for (k = 0; k < 200 && chunk_q.size() < 7; k++) begin
            @(posedge CLK);
            #1;
        end
        reset = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        @(negedge CLK);
        check("abort_valid", {31'd0, valid}, 0);
        check("abort_req_ready", {31'd0, req_ready}, 1);
        repeat (5) @(posedge CLK);
        #1;
        check("abort_no_ts", ts_cnt, 0);
        issue_req(4'd6, 3'd1, 5'd2);
        finish_packet(4'd6, 5'd2, 8'h31, 1'b0, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
